// File: rtl/ram_byte_streamer_pkg.sv
// Shared constants and FSM state type for the RAM byte streamer.
package ram_stream_pkg;

  localparam int ADDR_W         = 19;
  localparam int DATA_W         = 16;
  localparam int BYTES_PER_WORD = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ram_byte_streamer_if.sv
// Control, RAM port B and byte-stream signals of the RAM byte streamer.
// The master modport is the streamer itself; slave is its environment.
interface ram_byte_streamer_if;
  import ram_stream_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_q;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, base_addr, word_count, ram_q, out_ready,
    output busy, done, ram_address, out_byte, out_valid
  );

  modport slave (
    output start, base_addr, word_count, ram_q, out_ready,
    input  busy, done, ram_address, out_byte, out_valid
  );

endinterface

// File: rtl/ram_byte_streamer_fifo.sv
// Small show-ahead synchronous FIFO holding RAM words between the read
// latency pipe and the byte serialiser. Head data is visible while not empty.
module ram_word_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  // The issue credit rule upstream must make overflow and underflow impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(i_push && o_full));
  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n) !(i_pop && o_empty));

endmodule

// File: rtl/ram_byte_streamer.sv
// Reads a contiguous range of RAM words through port B and streams them out
// as bytes, low byte first. Reads are issued only while the words already in
// flight plus those buffered fit in the FIFO, so back-pressure never loses data.
module ram_byte_streamer
  import ram_stream_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_byte_streamer_if.master bus
);

  // A token spends one cycle with its address on ram_address and then RD_LAT
  // cycles of RAM latency; it leaves the pipe in the cycle ram_q holds its word.
  localparam int PIPE_D = RD_LAT + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int INF_W  = $clog2(PIPE_D + FIFO_DEPTH + 1);
  localparam int BYTE_W = DATA_W / BYTES_PER_WORD;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_issued;
  logic [ADDR_W-1:0] r_ram_address;
  logic [PIPE_D-1:0] r_pipe;
  logic [DATA_W-1:0] r_out_word;
  logic              r_out_hi;
  logic              r_out_valid;

  logic              w_issue;
  logic              w_last_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_fire;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [DATA_W-1:0] w_fifo_data;
  logic [INF_W-1:0]  w_pipe_cnt;
  logic [INF_W-1:0]  w_inflight;
  logic              w_drained;

  ram_word_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (bus.ram_q),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // Count tokens in the latency pipe; together with FIFO occupancy this is the credit in use.
  always_comb begin
    w_pipe_cnt = '0;
    for (int i = 0; i < PIPE_D; i++) begin
      w_pipe_cnt = w_pipe_cnt + INF_W'(r_pipe[i]);
    end
  end

  assign w_inflight   = w_pipe_cnt + INF_W'(w_fifo_count);
  assign w_issue      = (r_state == RUN) && (r_issued != r_count) &&
                        (w_inflight < INF_W'(FIFO_DEPTH));
  assign w_last_issue = w_issue && ((r_issued + ADDR_W'(1)) == r_count);
  assign w_push       = r_pipe[PIPE_D-1];
  assign w_fire       = r_out_valid && bus.out_ready;
  assign w_pop        = !w_fifo_empty && (!r_out_valid || (w_fire && r_out_hi));
  assign w_drained    = (r_pipe == '0) && w_fifo_empty && !r_out_valid;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is only honoured in IDLE, so no request is queued.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_next = (bus.word_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_last_issue) begin
          w_state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_drained) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    bus.busy = (r_state == RUN) || (r_state == DRAIN);
    bus.done = (r_state == DONE);
  end

  // Transfer capture, read issue and latency pipe; ram_address holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base        <= '0;
      r_count       <= '0;
      r_issued      <= '0;
      r_ram_address <= '0;
      r_pipe        <= '0;
    end else begin
      r_pipe <= {r_pipe[PIPE_D-2:0], w_issue};
      if ((r_state == IDLE) && bus.start) begin
        r_base   <= bus.base_addr;
        r_count  <= bus.word_count;
        r_issued <= '0;
      end else if (w_issue) begin
        r_ram_address <= r_base + r_issued;
        r_issued      <= r_issued + ADDR_W'(1);
      end
    end
  end

  // Byte serialiser: load a word, send its low byte then its high byte, and
  // load the next word on the same edge the high byte goes so bytes flow every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_word  <= '0;
      r_out_hi    <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_pop) begin
      r_out_word  <= w_fifo_data;
      r_out_hi    <= 1'b0;
      r_out_valid <= 1'b1;
    end else if (w_fire) begin
      if (!r_out_hi) begin
        r_out_hi <= 1'b1;
      end else begin
        r_out_hi    <= 1'b0;
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.ram_address = r_ram_address;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_byte    = r_out_hi ? r_out_word[DATA_W-1:BYTE_W] : r_out_word[BYTE_W-1:0];

endmodule

// File: tb/tb_ram_byte_streamer.sv
// Bench for ram_byte_streamer: a two-stage registered RAM model, a queue of
// expected bytes derived from RAM contents, and one compare process that
// checks every accepted byte, stall stability and FIFO occupancy.
module tb_ram_byte_streamer;

  localparam int AW = ram_stream_pkg::ADDR_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ram_byte_streamer_if bus();

  ram_byte_streamer #(
    .RD_LAT     (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM port B model: registered address, then registered output.
  logic [15:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] ramAddrQ;
  always @(posedge clk) begin
    ramAddrQ  <= bus.ram_address;
    bus.ram_q <= mem[ramAddrQ];
  end

  int            checks = 0;
  int            errors = 0;
  logic [7:0]    expQ[$];
  logic [7:0]    gotQ[$];
  logic [AW-1:0] addrQ[$];
  logic [AW-1:0] lastAddr = '0;
  int            doneCount = 0;
  int            acceptCount = 0;
  int            readyMode = 0;
  int            cyc = 0;
  int            stallStart = 0;
  logic          prevValid = 1'b0;
  logic          prevReady = 1'b0;
  logic [7:0]    prevByte = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Expected byte stream of a transfer: each word low byte then high byte,
  // addresses wrapping modulo the RAM size.
  task automatic modelTransfer(input logic [AW-1:0] base, input logic [AW-1:0] count);
    logic [AW-1:0] a;
    for (int w = 0; w < int'(count); w++) begin
      a = base + AW'(w);
      expQ.push_back(mem[a][7:0]);
      expQ.push_back(mem[a][15:8]);
    end
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW-1:0] count, input bit modelIt);
    if (modelIt) modelTransfer(base, count);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = base;
    bus.word_count = count;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int c0;
    int n;
    c0 = doneCount;
    n  = 0;
    while (doneCount == c0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput({name, "_done_seen"}, 32'(doneCount != c0), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput({name, "_single_done"}, 32'(doneCount), 32'(c0 + 1));
    checkOutput({name, "_busy_low"}, 32'(bus.busy), 32'd0);
    checkOutput({name, "_all_bytes_out"}, 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, "_busy"}, 32'(bus.busy), 32'd0);
    checkOutput({name, "_done"}, 32'(bus.done), 32'd0);
    checkOutput({name, "_ram_address"}, 32'(bus.ram_address), 32'd0);
    checkOutput({name, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({name, "_out_byte"}, 32'(bus.out_byte), 32'd0);
  endtask

  // Downstream ready pattern: always, 1-of-3 with a 20-cycle stall, or random.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (readyMode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 3 == 0) && !(cyc >= stallStart && cyc < stallStart + 20);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
      lastAddr  = '0;
    end else begin
      if (bus.done) doneCount++;
      if (bus.ram_address != lastAddr) begin
        addrQ.push_back(bus.ram_address);
        lastAddr = bus.ram_address;
      end
      checkOutput("fifo_occupancy", 32'(dut.u_fifo.o_count <= 3'd4), 32'd1);
      if (prevValid && !prevReady) begin
        checkOutput("stall_valid_held", 32'(bus.out_valid), 32'd1);
        checkOutput("stall_byte_stable", 32'(bus.out_byte), 32'(prevByte));
      end
      if (bus.out_valid && bus.out_ready) begin
        acceptCount++;
        gotQ.push_back(bus.out_byte);
        checkOutput("byte_was_expected", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) checkOutput("stream_byte", 32'(bus.out_byte), 32'(expQ.pop_front()));
      end
      prevValid = bus.out_valid;
      prevReady = bus.out_ready;
      prevByte  = bus.out_byte;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [AW-1:0] a0;
    int            acc0;
    int            done0;
    int            n;
    logic [AW-1:0] rb;
    logic [AW-1:0] rc;

    bus.start      = 1'b0;
    bus.base_addr  = '0;
    bus.word_count = '0;
    #23;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream: two words, low byte first.
    mem[0] = 16'heeaa;
    mem[1] = 16'h00ff;
    gotQ.delete();
    applyStimulus(19'h00000, 19'd2, 1'b1);
    checkOutput("basic_busy_after_start", 32'(bus.busy), 32'd1);
    waitDone("basic", 200);
    checkOutput("basic_nbytes", 32'(gotQ.size()), 32'd4);
    if (gotQ.size() == 4) begin
      checkOutput("basic_b0", 32'(gotQ[0]), 32'h aa);
      checkOutput("basic_b1", 32'(gotQ[1]), 32'h ee);
      checkOutput("basic_b2", 32'(gotQ[2]), 32'h ff);
      checkOutput("basic_b3", 32'(gotQ[3]), 32'h 00);
    end

    // Zero count: done on the cycle after the start edge, nothing streamed.
    a0   = bus.ram_address;
    acc0 = acceptCount;
    done0 = doneCount;
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = 19'h01234;
    bus.word_count = '0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checkOutput("zero_done_pulse", 32'(bus.done), 32'd1);
    checkOutput("zero_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("zero_done_dropped", 32'(bus.done), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zero_addr_held", 32'(bus.ram_address), 32'(a0));
    checkOutput("zero_no_bytes", 32'(acceptCount), 32'(acc0));
    checkOutput("zero_no_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("zero_one_done", 32'(doneCount), 32'(done0 + 1));

    // Back-pressure: 1-of-3 ready plus a long stall.
    for (int i = 0; i < 8; i++) mem[19'h10 + i] = 16'h0100 + 16'(i);
    gotQ.delete();
    readyMode  = 1;
    stallStart = cyc + 12;
    applyStimulus(19'h00010, 19'd8, 1'b1);
    waitDone("backpressure", 1000);
    readyMode = 0;
    checkOutput("bp_nbytes", 32'(gotQ.size()), 32'd16);
    if (gotQ.size() == 16) begin
      checkOutput("bp_b0", 32'(gotQ[0]), 32'h00);
      checkOutput("bp_b1", 32'(gotQ[1]), 32'h01);
      checkOutput("bp_b14", 32'(gotQ[14]), 32'h07);
      checkOutput("bp_b15", 32'(gotQ[15]), 32'h01);
    end

    // Address wrap past the top of the RAM.
    mem[19'h7FFFE] = 16'ha1b2;
    mem[19'h7FFFF] = 16'hc3d4;
    mem[19'h00000] = 16'he5f6;
    mem[19'h00001] = 16'h0718;
    addrQ.delete();
    applyStimulus(19'h7FFFE, 19'd4, 1'b1);
    waitDone("wrap", 300);
    checkOutput("wrap_naddr", 32'(addrQ.size()), 32'd4);
    if (addrQ.size() == 4) begin
      checkOutput("wrap_a0", 32'(addrQ[0]), 32'h7FFFE);
      checkOutput("wrap_a1", 32'(addrQ[1]), 32'h7FFFF);
      checkOutput("wrap_a2", 32'(addrQ[2]), 32'h00000);
      checkOutput("wrap_a3", 32'(addrQ[3]), 32'h00001);
    end

    // Reset while the third byte is on the stream aborts with no done.
    for (int i = 0; i < 4; i++) mem[19'h400 + i] = 16'h5a00 + 16'(i);
    acc0  = acceptCount;
    applyStimulus(19'h00400, 19'd4, 1'b1);
    n = 0;
    while (acceptCount < acc0 + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    checkOutput("rst_mid_reached", 32'(acceptCount >= acc0 + 2), 32'd1);
    done0 = doneCount;
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("rst_mid");
    expQ.delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mid_no_done", 32'(doneCount), 32'(done0));
    checkOutput("rst_mid_held_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) mem[19'h500 + i] = 16'h6b10 + 16'(i);
    gotQ.delete();
    applyStimulus(19'h00500, 19'd3, 1'b1);
    waitDone("rst_restart", 300);
    checkOutput("rst_restart_nbytes", 32'(gotQ.size()), 32'd6);
    if (gotQ.size() == 6) checkOutput("rst_restart_b0", 32'(gotQ[0]), 32'h10);

    // Start while busy is ignored.
    for (int i = 0; i < 6; i++) mem[19'h200 + i] = 16'h7700 + 16'(i);
    for (int i = 0; i < 3; i++) mem[19'h300 + i] = 16'h8800 + 16'(i);
    applyStimulus(19'h00200, 19'd6, 1'b1);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.base_addr  = 19'h00300;
    bus.word_count = 19'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    waitDone("busy_start", 400);
    checkOutput("busy_start_last_addr", 32'(bus.ram_address), 32'h00205);

    // Randomised transfers under random back-pressure.
    readyMode = 2;
    for (int t = 0; t < 6; t++) begin
      rb = AW'($urandom_range(0, (1 << AW) - 1));
      rc = AW'($urandom_range(1, 24));
      for (int i = 0; i < int'(rc); i++) mem[rb + AW'(i)] = 16'($urandom);
      applyStimulus(rb, rc, 1'b1);
      waitDone("random", 2000);
    end
    readyMode = 0;

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
